// File: rtl/leaf_out_arbiter.sv
// Round-robin burst arbiter sharing one leaf-interface output stream among NUM_REQ producers.
// Optional early grant release on a producer gap: define ARB_GAP_RELEASE_EN.
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int BURST_LEN    = 16
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0]                 din_user2arb,
  input  logic [NUM_REQ-1:0]                              vld_user2arb,
  output logic [NUM_REQ-1:0]                              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]                         dout_arb2interface,
  output logic                                            vld_arb2interface,
  input  logic                                            ack_interface2arb,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                            busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                  state_q;
  logic [GW-1:0]           ptr_q;
  logic [GW-1:0]           grant_q;
  logic [CW-1:0]           cnt_q;
  logic [PAYLOAD_BITS-1:0] dout_q;
  logic                    vld_q;

  logic [GW-1:0]           pick_s;
  logic [GW-1:0]           next_ptr_s;
  logic [PAYLOAD_BITS-1:0] sel_data_s;
  logic                    found_s;
  logic                    room_s;
  logic                    accept_s;
  logic                    last_s;
  logic                    gap_s;

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % NUM_REQ);
  endfunction

  // Round-robin search starting at ptr; lowest offset from ptr wins.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {GW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      found_s = found_s | vld_user2arb[wrap_add(ptr_q, k)];
      pick_s  = vld_user2arb[wrap_add(ptr_q, k)] ? wrap_add(ptr_q, k) : pick_s;
    end
  end

  // Accept decision: output register free or draining this cycle; never during reset.
  always_comb begin
    room_s     = ~vld_q | ack_interface2arb;
    accept_s   = ~reset & (state_q == ST_BURST) & vld_user2arb[grant_q] & room_s;
    last_s     = (cnt_q == CW'(BURST_LEN - 1));
    next_ptr_s = wrap_add(grant_q, 1);
    sel_data_s = din_user2arb[int'(grant_q) * PAYLOAD_BITS +: PAYLOAD_BITS];
`ifdef ARB_GAP_RELEASE_EN
    gap_s      = (state_q == ST_BURST) & ~vld_user2arb[grant_q] & room_s;
`else
    gap_s      = 1'b0;
`endif
    ack_arb2user = accept_s ? (NUM_REQ'(1'b1) << grant_q) : {NUM_REQ{1'b0}};
  end

  // Grant FSM plus the single output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= {GW{1'b0}};
      grant_q <= {GW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      vld_q   <= 1'b0;
      dout_q  <= {PAYLOAD_BITS{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_s) begin
            grant_q <= pick_s;
            cnt_q   <= {CW{1'b0}};
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept_s) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_s) begin
              ptr_q   <= next_ptr_s;
              state_q <= ST_IDLE;
            end
          end else if (gap_s) begin
            ptr_q   <= next_ptr_s;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A new load wins over a simultaneous drain, so valid stays high.
      if (accept_s) begin
        dout_q <= sel_data_s;
        vld_q  <= 1'b1;
      end else if (vld_q && ack_interface2arb) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign dout_arb2interface = dout_q;
  assign vld_arb2interface  = vld_q;
  assign grant_id           = grant_q;
  assign busy               = (state_q == ST_BURST);

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench: u_dut16 (BURST_LEN=16) and u_dut2 (BURST_LEN=2), producer/sink models per DUT.
module tb_leaf_out_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s  [2];
  logic [127:0] din_s  [2];
  logic [3:0]   vld_s  [2];
  logic [3:0]   uack_s [2];
  logic [31:0]  dout_s [2];
  logic         vldo_s [2];
  logic         iack_s [2];
  logic [1:0]   gid_s  [2];
  logic         busy_s [2];

  int          total = 0;
  int          bad   = 0;
  int          seq      [2][4];
  int          rem      [2][4];
  bit          ack_plan [2];
  logic [31:0] out_w  [2][$];
  int          out_c  [2][$];
  int          acc_c  [2][$];
  bit          busy_q [2][$];
  logic [1:0]  gid_q  [2][$];

  leaf_out_arbiter #(.PAYLOAD_BITS(32), .NUM_REQ(4), .BURST_LEN(16)) u_dut16 (
    .clk(clk), .reset(rst_s[0]), .din_user2arb(din_s[0]), .vld_user2arb(vld_s[0]),
    .ack_arb2user(uack_s[0]), .dout_arb2interface(dout_s[0]), .vld_arb2interface(vldo_s[0]),
    .ack_interface2arb(iack_s[0]), .grant_id(gid_s[0]), .busy(busy_s[0])
  );

  leaf_out_arbiter #(.PAYLOAD_BITS(32), .NUM_REQ(4), .BURST_LEN(2)) u_dut2 (
    .clk(clk), .reset(rst_s[1]), .din_user2arb(din_s[1]), .vld_user2arb(vld_s[1]),
    .ack_arb2user(uack_s[1]), .dout_arb2interface(dout_s[1]), .vld_arb2interface(vldo_s[1]),
    .ack_interface2arb(iack_s[1]), .grant_id(gid_s[1]), .busy(busy_s[1])
  );

  function automatic logic [31:0] word(input int p, input int s);
    return {8'(p), 24'(s)};
  endfunction

  function automatic logic [31:0] getw(input int d, input int k);
    if (k < out_w[d].size()) return out_w[d][k];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int getc(input int d, input int k);
    if (k < out_c[d].size()) return out_c[d][k];
    return -1000;
  endfunction

  function automatic int geta(input int d, input int k);
    if (k < acc_c[d].size()) return acc_c[d][k];
    return -1000;
  endfunction

  function automatic int first_busy(input int d);
    for (int i = 0; i < busy_q[d].size(); i++) if (busy_q[d][i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, then log what the next rising edge will transfer.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      iack_s[d] = ack_plan[d];
      for (int p = 0; p < 4; p++) begin
        vld_s[d][p] = (rem[d][p] > 0);
        din_s[d][p*32 +: 32] = word(p, seq[d][p]);
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (vldo_s[d] && iack_s[d]) begin
        out_w[d].push_back(dout_s[d]);
        out_c[d].push_back(busy_q[d].size());
      end
      if (uack_s[d] != 4'b0000) begin
        acc_c[d].push_back(busy_q[d].size());
        chk("ack_matches_grant", 32'(uack_s[d]), 32'(4'b0001 << gid_s[d]));
      end
      busy_q[d].push_back(busy_s[d]);
      gid_q[d].push_back(gid_s[d]);
      for (int p = 0; p < 4; p++) begin
        if (uack_s[d][p]) begin
          seq[d][p]++;
          rem[d][p]--;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int d);
    rst_s[d] = 1'b1;
    for (int p = 0; p < 4; p++) begin
      rem[d][p] = 0;
      seq[d][p] = 0;
    end
    cycle();
    cycle();
    rst_s[d] = 1'b0;
    out_w[d].delete();
    out_c[d].delete();
    acc_c[d].delete();
    busy_q[d].delete();
    gid_q[d].delete();
  endtask

  initial begin
    int fb;
    int lb;
    int z;
    int exp_p [10];
    int exp_s [10];

    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      iack_s[d] = 1'b0;
      ack_plan[d] = 1'b0;
      vld_s[d] = 4'b0000;
      din_s[d] = 128'd0;
    end

    // Reset state of both instances
    do_reset(0);
    do_reset(1);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(uack_s[d]), 32'd0);
      chk("rst_vld", 32'(vldo_s[d]), 32'd0);
      chk("rst_dout", dout_s[d], 32'd0);
      chk("rst_gid", 32'(gid_s[d]), 32'd0);
      chk("rst_busy", 32'(busy_s[d]), 32'd0);
    end

    // Single producer 2 offers 20 words, sink always ready
    ack_plan[0] = 1'b1;
    rem[0][2] = 20;
    run(40);
    chk("single_count", 32'(out_w[0].size()), 32'd20);
    for (int k = 0; k < 20; k++) chk("single_data", getw(0, k), word(2, k));
    chk("single_b2b", 32'(getc(0, 15) - getc(0, 0)), 32'd15);
    chk("single_gap", 32'(getc(0, 16) - getc(0, 15)), 32'd2);
    fb = first_busy(0);
    lb = -1;
    z = 0;
    for (int i = 0; i < busy_q[0].size(); i++) if (busy_q[0][i]) lb = i;
    for (int i = (fb < 0) ? 0 : fb; i < lb; i++) if (!busy_q[0][i]) z++;
    chk("single_idle_cycles", 32'(z), 32'd1);
    z = 0;
    for (int i = 0; i < busy_q[0].size(); i++) if (busy_q[0][i] && gid_q[0][i] != 2'd2) z++;
    chk("single_gid", 32'(z), 32'd0);

    // Round robin, BURST_LEN=2, all four producers continuously valid
    exp_p = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp_s = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
    ack_plan[1] = 1'b1;
    for (int p = 0; p < 4; p++) rem[1][p] = 100;
    run(20);
    for (int k = 0; k < 10; k++) chk("rr_order", getw(1, k), word(exp_p[k], exp_s[k]));
    chk("rr_10_words_timing", 32'(geta(1, 9) - first_busy(1)), 32'd13);
    for (int p = 0; p < 4; p++) rem[1][p] = 0;

    // Backpressure: sink stalls 5 cycles mid-burst
    do_reset(0);
    ack_plan[0] = 1'b1;
    rem[0][1] = 12;
    run(6);
    ack_plan[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_vld_hold", 32'(vldo_s[0]), 32'd1);
      chk("bp_dout_hold", dout_s[0], word(1, out_w[0].size()));
      chk("bp_no_ack", 32'(uack_s[0]), 32'd0);
    end
    ack_plan[0] = 1'b1;
    run(25);
    chk("bp_count", 32'(out_w[0].size()), 32'd12);
    for (int k = 0; k < 12; k++) chk("bp_data", getw(0, k), word(1, k));

    // Gap: producer 0 stops after 3 words while producer 1 waits
    do_reset(0);
    ack_plan[0] = 1'b1;
    rem[0][0] = 3;
    rem[0][1] = 20;
    run(14);
    rem[0][0] = 13;
    run(40);
`ifdef ARB_GAP_RELEASE_EN
    for (int k = 0; k < 19; k++)
      chk("gap_order", getw(0, k), (k < 3) ? word(0, k) : word(1, k - 3));
`else
    for (int k = 0; k < 17; k++)
      chk("gap_order", getw(0, k), (k < 16) ? word(0, k) : word(1, 0));
`endif

    // Reset in the middle of producer 3's burst, after producer 2 moved ptr to 3
    do_reset(0);
    ack_plan[0] = 1'b1;
    rem[0][2] = 16;
    rem[0][3] = 30;
    for (int i = 0; i < 80 && seq[0][3] < 5; i++) cycle();
    chk("mid_words", 32'(seq[0][3]), 32'd5);
    @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    rem[0][1] = 30;
    cycle();
    chk("mid_rst_noack", 32'(uack_s[0]), 32'd0);
    chk("mid_full_vld", 32'(vldo_s[0]), 32'd1);
    chk("mid_full_dout", dout_s[0], word(3, 4));
    cycle();
    chk("mid_after_vld", 32'(vldo_s[0]), 32'd0);
    chk("mid_after_dout", dout_s[0], 32'd0);
    chk("mid_after_gid", 32'(gid_s[0]), 32'd0);
    chk("mid_after_busy", 32'(busy_s[0]), 32'd0);
    chk("mid_after_ack", 32'(uack_s[0]), 32'd0);
    rst_s[0] = 1'b0;
    out_w[0].delete();
    run(6);
    chk("mid_first_word", getw(0, 0), word(1, 0));
    chk("mid_first_gid", 32'(gid_s[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin burst arbiter that shares one leaf-interface output port (user→interface direction, `vld`/`ack` stream) among `NUM_REQ` user-side producers. It sits between the user kernel wrapper and `leaf_interface`, so several kernel output streams can share one BFT output port without interleaving inside a burst. Grants are held for up to `BURST_LEN` words. The output is driven from a single registered stage.

## Interface
- `PAYLOAD_BITS`, 32, stream data width.
- `NUM_REQ`, 4, number of producers (≥1).
- `BURST_LEN`, 16, maximum words per grant (≥1).
- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `din_user2arb` input `NUM_REQ*PAYLOAD_BITS`: producer data; producer i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- `vld_user2arb` input `NUM_REQ`: producer valid, one bit per producer.
- `ack_arb2user` output `NUM_REQ`: producer accept, one-hot or zero.
- `dout_arb2interface` output `PAYLOAD_BITS`: data to `leaf_interface`.
- `vld_arb2interface` output 1: output valid.
- `ack_interface2arb` input 1: interface accept.
- `grant_id` output `max(1,$clog2(NUM_REQ))`: current or last granted producer.
- `busy` output 1: high while in the BURST state.

## Operation
- Handshake: a word transfers on any cycle where vld && ack are both high. Producers must hold data and valid stable until accepted.
- State IDLE:
  - Search `vld_user2arb` round-robin, starting at `ptr` and wrapping modulo `NUM_REQ`.
  - On finding a requester g: register `grant_id`=g, clear `cnt`, go to BURST.
  - No word is accepted while in IDLE.
- State BURST:
  - `accept` = `vld_user2arb[g]` & (~`vld_arb2interface` | `ack_interface2arb`).
  - `ack_arb2user[g]` = `accept`. This path is combinational from `ack_interface2arb`.
  - On `accept`: load the word into the output register, set `vld_arb2interface`, and increment `cnt`.
  - Release the grant when the accepted word is word number `BURST_LEN` (`cnt`==`BURST_LEN`-1 at accept).
  - On release: `ptr`=(g+1) mod `NUM_REQ`, go to IDLE.
- Output register: when `vld_arb2interface` && `ack_interface2arb` and no new accept occurs, clear `vld_arb2interface`. Data holds while valid and not acked.
- `cnt` width is `$clog2(BURST_LEN+1)` bits. It never wraps, because release happens at `BURST_LEN`-1.
- Simultaneous events: output drain and a new load in the same cycle → the new word wins and valid stays high.
- Release does not wait for the output register to drain. The next grant may start while the last word is still pending.
- `NUM_REQ`=1: the grant always returns to producer 0. `BURST_LEN`=1: one word per grant.

## Timing
- Reset values:
  - `ack_arb2user`=0, `vld_arb2interface`=0, `dout_arb2interface`=0, `grant_id`=0, `busy`=0.
  - State IDLE, `ptr`=0, `cnt`=0.
- Reset mid-burst:
  - Any pending output word is discarded.
  - No `ack_arb2user` is asserted in the reset cycle.
- Arbitration costs 1 cycle. If request is seen in IDLE at cycle N, BURST starts at N+1 and the first accept can occur at N+1.
- Latency: a word accepted at cycle N appears on `dout_arb2interface` at N+1.
- Throughput: 1 word per cycle within a burst while `ack_interface2arb` is high.
- Per-grant cost: one dead cycle per grant.

## Configuration
- `ARB_GAP_RELEASE_EN` defined:
  - In BURST, a cycle with `vld_user2arb[g]`=0 and (~`vld_arb2interface` | `ack_interface2arb`) releases the grant early.
  - On early release: `ptr`=g+1, return to IDLE.
  - A producer that idles cannot stall the port.
- Not defined:
  - The grant is held until `BURST_LEN` words are accepted, regardless of gaps.
  - Bursts are strictly contiguous per producer.

## Test plan
- Single producer, `BURST_LEN`=16: producer 2 offers 20 words with ack high.
  - Required: 16 words out back-to-back, then `busy` low for exactly 1 cycle, then 4 words.
  - Data order is preserved; `grant_id`=2 throughout.
- Round robin, all 4 producers continuously valid, `BURST_LEN`=2.
  - Required grant sequence: 0,0,1,1,2,2,3,3,0,0.
  - 10 words out in 14 cycles after the first grant.
- Backpressure: drop `ack_interface2arb` for 5 cycles mid-burst.
  - `dout_arb2interface` and `vld_arb2interface` stay stable.
  - `ack_arb2user` is 0 while the output register is full.
  - No words are lost or duplicated.
- Gap (with `ARB_GAP_RELEASE_EN`): producer 0 sends 3 words, drops valid, while producer 1 is valid.
  - Required: grant moves to 1 after one IDLE cycle.
  - Without the macro, the grant stays at 0 until word 16.
- Reset mid-burst after 5 words, with the output register full.
  - The next cycle shows all outputs 0 and state IDLE.
  - The first post-reset grant goes to the lowest valid producer, starting from `ptr`=0.
- Simultaneous drain+load: ack high every cycle with a continuous source; `vld_arb2interface` never drops inside the burst.
